// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a small byte FIFO, read as a memory-mapped status/data word.
// Revision 1.0
`default_nettype none

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        pop,
  output logic [31:0] uart_data,
  output logic        rx_busy
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        rx_meta;
  logic        rxs;
  logic        armed;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        overrun;
  logic        frame_err;

  logic        empty;
  logic        full;
  logic        push;
  logic        frame_set;
  logic        do_pop;
  logic        do_push;
  logic        ovr_set;
  logic [7:0]  head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // armed blocks a start until the line has been seen idle after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      armed <= 1'b0;
    end else begin
      if (rxs) armed <= 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (armed && !rxs) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            idx <= '0;
            state <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == 3'd7) state <= STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign push      = (state == STOP) && (cnt == BIT_LAST) && rxs;
  assign frame_set = (state == STOP) && (cnt == BIT_LAST) && !rxs;

  // extra pointer bit distinguishes full from empty when indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovr_set = push && full && !do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (ovr_set)       overrun <= 1'b1;
      else if (pop)      overrun <= 1'b0;
      if (frame_set)     frame_err <= 1'b1;
      else if (pop)      frame_err <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  assign head      = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign uart_data = {21'd0, frame_err, overrun, !empty, head};
  assign rx_busy   = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with CLKS_PER_BIT=8, FIFO_DEPTH=4.
`default_nettype none

module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        pop;
  logic [31:0] uart_data;
  logic        rx_busy;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .pop(pop),
    .uart_data(uart_data), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // start bit plus eight data bits, each 8 clocks, called on a falling edge
  task automatic send_head(input logic [7:0] b);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_head(b);
    rx = stop;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_pop();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    pop = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", uart_data, 32'h0);
    check("reset_busy", {31'd0, rx_busy}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5: exact one-cycle latency after stop sample
    send_head(8'hA5);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    check("a5_before_stop", uart_data, 32'h0);
    check("a5_busy_in_stop", {31'd0, rx_busy}, 32'h1);
    @(negedge clk);
    check("a5_after_stop", uart_data, 32'h0000_01A5);
    check("a5_idle", {31'd0, rx_busy}, 32'h0);
    repeat (4) @(negedge clk);
    do_pop();
    check("a5_pop", uart_data, 32'h0);
    do_pop();
    check("pop_empty", uart_data, 32'h0);

    // fill plus one overflowing byte
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("full_no_ovr", uart_data, 32'h0000_0111);
    send_byte(8'h55, 1'b1);
    check("overrun", uart_data, 32'h0000_0311);
    do_pop();
    check("ovr_pop1", uart_data, 32'h0000_0122);
    do_pop();
    check("ovr_pop2", uart_data, 32'h0000_0133);
    do_pop();
    check("ovr_pop3", uart_data, 32'h0000_0144);
    do_pop();
    check("ovr_pop4", uart_data, 32'h0);

    // framing error
    send_byte(8'h3C, 1'b0);
    repeat (10) @(negedge clk);
    check("frame_err", uart_data, 32'h0000_0400);
    do_pop();
    check("frame_pop", uart_data, 32'h0);

    // 2-cycle glitch on idle line
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_busy", {31'd0, rx_busy}, 32'h1);
    repeat (20) @(negedge clk);
    check("glitch_idle", {31'd0, rx_busy}, 32'h0);
    check("glitch_data", uart_data, 32'h0);

    // full FIFO, pop on the stop-sample edge of a fifth byte
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    check("full2", uart_data, 32'h0000_0101);
    send_head(8'h05);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    do_pop();
    check("simul_push_pop", uart_data, 32'h0000_0102);
    repeat (8) @(negedge clk);
    do_pop();
    check("simul_pop2", uart_data, 32'h0000_0103);
    do_pop();
    check("simul_pop3", uart_data, 32'h0000_0104);
    do_pop();
    check("simul_pop4", uart_data, 32'h0000_0105);
    do_pop();
    check("simul_pop5", uart_data, 32'h0);

    // reset during DATA of 0x7E
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b0; repeat (8) @(negedge clk);
    rx = 1'b1; repeat (8) @(negedge clk);
    rx = 1'b1; repeat (4) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check("rst_mid_data", uart_data, 32'h0);
    check("rst_mid_busy", {31'd0, rx_busy}, 32'h0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("after_rst_data", uart_data, 32'h0);
    check("after_rst_busy", {31'd0, rx_busy}, 32'h0);
    send_byte(8'h81, 1'b1);
    check("after_rst_81", uart_data, 32'h0000_0181);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set clock cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set receive FIFO depth in bytes; power of two, 2..16.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  SHALL be reset, asynchronous, active-high.
REQ-005 rx  input  1  SHALL be the serial line, asynchronous, idle high, 8N1, LSB first.
REQ-006 pop  input  1  SHALL be a one-cycle pulse from the core, asserted when it reads the UART word at address 0x4000.
REQ-007 uart_data  output  32  SHALL be the word the RAM returns at 0x4000: [7:0] head byte, [8] valid, [9] overrun, [10] frame_err, [31:11] zero.
REQ-008 rx_busy  output  1  SHALL be high whenever the receiver FSM is not IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; the FSM SHALL see only the synchronized value rxs.
REQ-010 The FSM SHALL have states IDLE, START, DATA, STOP and a bit-period counter cnt plus a 3-bit bit index.
REQ-011 IDLE: on rxs==0 -> START with cnt=0.
REQ-012 START: at cnt==CLKS_PER_BIT/2-1, if rxs==0 -> DATA with cnt=0 and index=0; if rxs==1 -> IDLE (glitch rejected, nothing recorded).
REQ-013 DATA: at cnt==CLKS_PER_BIT-1, shift rxs into the shift register at bit[index], cnt=0; after index 7 -> STOP.
REQ-014 STOP: at cnt==CLKS_PER_BIT-1, sample rxs; 1 -> push byte; 0 -> discard byte and set frame_err; either way -> IDLE.
REQ-015 A push SHALL write the FIFO on the same edge as the stop sample; the byte SHALL appear on uart_data[7:0] with valid=1 in the next cycle when the FIFO was empty.
REQ-016 valid SHALL equal FIFO not-empty; uart_data[7:0] SHALL be 0 while empty.
REQ-017 pop with FIFO non-empty SHALL advance the read pointer by one; pop while empty SHALL leave pointers unchanged.
REQ-018 A push to a full FIFO SHALL drop the new byte, leave contents unchanged and set overrun.
REQ-019 Simultaneous push and pop on a full FIFO SHALL accept both; no overrun; count unchanged.
REQ-020 Simultaneous push and pop on an empty FIFO SHALL store the byte; pop is ignored; count becomes 1.
REQ-021 overrun and frame_err SHALL be sticky and cleared by any pop; a set event in the same cycle as pop SHALL win (flag stays 1).
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit or an occupancy counter.
REQ-023 uart_data SHALL be driven combinationally from the FIFO head and the flag registers.

Reset
REQ-024 On rst: FSM=IDLE, cnt=0, index=0, synchronizer flops=1, FIFO empty, both flags=0, hence uart_data=0 and rx_busy=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no push; after release the receiver SHALL wait for rxs high then low before starting a new frame.

Verification (CLKS_PER_BIT=8, FIFO_DEPTH=4)
REQ-026 Send 0xA5 8N1 -> one cycle after stop sample, uart_data=0x000001A5; pop -> uart_data=0x00000000.
REQ-027 Send 0x11,0x22,0x33,0x44,0x55 without pop -> uart_data=0x00000311 (0x55 dropped, overrun=1); four pops yield 0x22,0x33,0x44 in turn, then 0x00000000, overrun cleared by the first pop.
REQ-028 Send 0x3C with stop bit low -> uart_data=0x00000400, FIFO empty; pop -> 0x00000000.
REQ-029 Low pulse of 2 cycles on idle rx -> FSM returns to IDLE, uart_data stays 0x00000000.
REQ-030 FIFO full, pop on the exact stop-sample edge of a fifth byte -> both accepted, overrun=0, occupancy stays 4.
REQ-031 Assert rst during DATA of byte 0x7E -> uart_data=0 and rx_busy=0 during and after reset, no byte delivered; a following full 0x81 frame -> 0x00000181.
